// File: rtl/qspi_flash_responder.sv
// Quad-SPI flash responder for Fast Read Quad Output (6Bh) from a preloadable byte array.
// Optional macro SPI_RESP_SINGLE_READ_EN adds Read (03h) with serial data on IO1.
module qspi_flash_responder #(
   parameter int MEM_BYTES = 4096,
   parameter int AW        = $clog2(MEM_BYTES)
) (
   input  logic          CLK,
   input  logic          ARESETn,
   input  logic          CS,
   inout  wire           IO0,
   inout  wire           IO1,
   inout  wire           IO2,
   inout  wire           IO3,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [7:0]    load_data,
   output logic          busy,
   output logic          cmd_err,
   output logic [AW-1:0] cur_addr
);

   typedef enum logic [2:0] {
      S_CMD,
      S_ADDR,
      S_DUMMY,
      S_DATA,
      S_IGNORE
   } state_t;

   logic [7:0]    r_mem [MEM_BYTES];
   state_t        r_state;
   logic [4:0]    r_cnt;
   logic [6:0]    r_sh;
   logic [AW-2:0] r_ash;
   logic [AW-1:0] r_addr;
   logic [AW-1:0] r_cur;
   logic [7:0]    r_byte;
   logic          r_ph;
   logic          r_sgl;
   logic [3:0]    r_oe;
   logic [3:0]    r_do;
   logic          r_busy;
   logic          r_err;

   logic [7:0]    w_cmd;
   logic [AW-1:0] w_a;
   logic [AW-1:0] w_nx;
   logic [AW-1:0] w_fa;
   logic [7:0]    w_fb;

   // Nibble bit3 goes to IO0, bit0 to IO3 (r_do index = IO number)
   function automatic logic [3:0] f_map(input logic [3:0] n);
      return {n[0], n[1], n[2], n[3]};
   endfunction

   assign w_cmd = {r_sh, IO0};
   assign w_a   = {r_ash, IO0};
   assign w_nx  = r_addr + 1'b1;

   // Fetch address: fresh address at end of ADDR, next byte in DATA
   always_comb begin
      w_fa = r_addr;
      if (r_state == S_ADDR) begin
         w_fa = w_a;
      end else if (r_state == S_DATA) begin
         w_fa = w_nx;
      end
      w_fb = r_mem[w_fa];
   end

   assign IO0 = r_oe[0] ? r_do[0] : 1'bz;
   assign IO1 = r_oe[1] ? r_do[1] : 1'bz;
   assign IO2 = r_oe[2] ? r_do[2] : 1'bz;
   assign IO3 = r_oe[3] ? r_do[3] : 1'bz;

   assign busy     = r_busy;
   assign cmd_err  = r_err;
   assign cur_addr = r_cur;

   // Preload port; contents survive reset
   always_ff @(posedge CLK) begin
      if (load_en) begin
         r_mem[load_addr] <= load_data;
      end
   end

   // Transaction FSM with registered IO drive and status outputs
   always_ff @(posedge CLK) begin
      if (!ARESETn) begin
         r_state <= S_CMD;
         r_cnt   <= '0;
         r_sh    <= '0;
         r_ash   <= '0;
         r_addr  <= '0;
         r_cur   <= '0;
         r_byte  <= '0;
         r_ph    <= 1'b0;
         r_sgl   <= 1'b0;
         r_oe    <= '0;
         r_do    <= '0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else if (CS) begin
         r_state <= S_CMD;
         r_cnt   <= '0;
         r_sh    <= '0;
         r_ash   <= '0;
         r_ph    <= 1'b0;
         r_sgl   <= 1'b0;
         r_oe    <= '0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         unique case (r_state)
            S_CMD: begin
               r_sh  <= w_cmd[6:0];
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'd7) begin
                  r_cnt <= '0;
                  if (w_cmd == 8'h6B) begin
                     r_state <= S_ADDR;
                     r_busy  <= 1'b1;
                     r_sgl   <= 1'b0;
                  end
`ifdef SPI_RESP_SINGLE_READ_EN
                  else if (w_cmd == 8'h03) begin
                     r_state <= S_ADDR;
                     r_busy  <= 1'b1;
                     r_sgl   <= 1'b1;
                  end
`endif
                  else begin
                     r_state <= S_IGNORE;
                     r_err   <= 1'b1;
                  end
               end
            end
            S_ADDR: begin
               r_ash <= w_a[AW-2:0];
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'd23) begin
                  r_cnt  <= '0;
                  r_addr <= w_a;
                  if (r_sgl) begin
                     r_state <= S_DATA;
                     r_cur   <= w_a;
                     r_byte  <= {w_fb[6:0], 1'b0};
                     r_do    <= {2'b00, w_fb[7], 1'b0};
                     r_oe    <= 4'b0010;
                     r_cnt   <= 5'd1;
                  end else begin
                     r_state <= S_DUMMY;
                  end
               end
            end
            S_DUMMY: begin
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'd7) begin
                  r_cnt   <= '0;
                  r_state <= S_DATA;
                  r_cur   <= r_addr;
                  r_byte  <= w_fb;
                  r_do    <= f_map(w_fb[7:4]);
                  r_oe    <= 4'hF;
                  r_ph    <= 1'b1;
               end
            end
            S_DATA: begin
               if (r_sgl) begin
                  if (r_cnt == 5'd8) begin
                     r_addr <= w_nx;
                     r_cur  <= w_nx;
                     r_byte <= {w_fb[6:0], 1'b0};
                     r_do   <= {2'b00, w_fb[7], 1'b0};
                     r_cnt  <= 5'd1;
                  end else begin
                     r_byte <= {r_byte[6:0], 1'b0};
                     r_do   <= {2'b00, r_byte[7], 1'b0};
                     r_cnt  <= r_cnt + 5'd1;
                  end
               end else if (r_ph) begin
                  r_do <= f_map(r_byte[3:0]);
                  r_ph <= 1'b0;
               end else begin
                  r_addr <= w_nx;
                  r_cur  <= w_nx;
                  r_byte <= w_fb;
                  r_do   <= f_map(w_fb[7:4]);
                  r_ph   <= 1'b1;
               end
            end
            S_IGNORE: begin
               r_oe <= '0;
            end
            default: begin
               r_state <= S_CMD;
            end
         endcase
      end
   end

endmodule

// File: doc/qspi_flash_responder.md
# qspi_flash_responder

Synthesizable Quad-SPI flash responder that acts as the memory end of the Fast Read Quad Output (6Bh) transaction issued by the team's QSPI flash initiator. It decodes instruction, 24-bit address and 8 dummy clocks, then drives the selected bytes as nibbles on IO0..IO3 from an internal preloadable byte array. It replaces the external W25Q64CV in simulation and FPGA emulation of the instruction-fetch path.

## Interface
- MEM_BYTES, 4096: byte array size; power of two, 16..65536.
- AW, $clog2(MEM_BYTES): internal byte-address width.
- CLK  in  1  SPI clock, shared with the initiator; all logic is on the rising edge.
- ARESETn  in  1  reset, synchronous, active-low.
- CS  in  1  chip select, active-low.
- IO0, IO1, IO2, IO3  inout  1 each  quad data lines; IO0 is input during instruction/address.
- load_en  in  1  preload write strobe.
- load_addr  in  AW  preload byte address.
- load_data  in  8  preload byte.
- busy  out  1  high while a supported transaction is in progress.
- cmd_err  out  1  one-cycle pulse on an unsupported instruction.
- cur_addr  out  AW  address of the byte currently being driven.

## Operation
- States: CMD, ADDR, DUMMY, DATA, IGNORE.
- CMD: shift IO0 MSB-first, 8 edges. 6Bh -> ADDR. Any other value -> IGNORE with a cmd_err pulse.
- ADDR: shift IO0 MSB-first, 24 edges. Bits [23:AW] are discarded; the address wraps modulo MEM_BYTES.
- DUMMY: 8 edges with IO lines released. On the 8th edge, fetch mem[addr] into the byte register and enter DATA.
- DATA: 2 edges per byte, high nibble first.
  - Nibble mapping: nibble bit3->IO0, bit2->IO1, bit1->IO2, bit0->IO3, matching the initiator's {IO0,IO1,IO2,IO3} capture.
  - After the low nibble, addr increments, wrapping MEM_BYTES-1 -> 0, and the next byte is fetched.
  - Output is unbounded until CS rises.
- IGNORE: IOs released and nothing sampled until CS rises.
- CS high on any edge: state -> CMD, counters cleared, IOs released, busy low. A partially received instruction or address is discarded.
- Preload:
  - load_en writes mem[load_addr] on any edge, independent of CS.
  - A byte is latched at fetch time, so a write to the byte already fetched is not visible until that address is read again.
- Memory contents are not affected by reset.

## Timing
- Edge n means the n-th rising CLK edge with CS low, counted from the CMD state.
- Instruction bits are sampled at edges 1-8, address bits at edges 9-32. Dummy edges are 33-40.
- First nibble (mem[A][7:4]) is registered at edge 40 and valid until edge 41, where the initiator samples it. Each subsequent nibble changes at the following edge.
- Output enables are registered. IOs are driven only in DATA, otherwise high-Z.
- Reset values: state CMD, IO0..IO3 high-Z, busy 0, cmd_err 0, cur_addr 0, all counters 0.
- Reset has priority over CS. Reset asserted mid-DATA releases the IOs at that edge.
- busy rises at edge 8 for a valid instruction and falls at the edge where CS is sampled high.
- cmd_err is high for exactly the edge-8 cycle of an unsupported instruction.
- cur_addr updates at the same edge as the first nibble of each byte.

## Configuration
- SPI_RESP_SINGLE_READ_EN defined: instruction 03h (Read) is supported.
  - 24 address bits follow with no dummy clocks.
  - Data is driven MSB-first on IO1 only, 1 bit per edge, 8 edges per byte. The first bit is registered at edge 32.
  - IO0, IO2 and IO3 stay high-Z.
  - Auto-increment and wrap are the same as for 6Bh.
- Not defined: 03h is treated as unsupported (IGNORE, cmd_err pulse).

## Test plan
- Basic quad read: preload mem[0x010..0x013] = 0xDE,0xAD,0xBE,0xEF; 6Bh, address 0x000010 -> nibbles D,E,A,D,B,E,E,F sampled at edges 41-48; busy high throughout; cur_addr steps 0x010..0x013.
- Wrap: MEM_BYTES=4096, preload mem[0xFFF]=0x5A and mem[0x000]=0xC3; read from 0x00FFF -> 5,A,C,3.
- Unsupported instruction: 9Fh -> cmd_err pulse at edge 8, IOs high-Z for 40 further edges; the next CS-low cycle with 6Bh reads correctly.
- Abort: CS rises after 12 address bits -> state CMD, busy 0; the following 6Bh to 0x000004 returns mem[4] unchanged.
- Reset mid-DATA: ARESETn low at edge 44 -> IOs high-Z at that edge, busy 0, cur_addr 0; memory contents preserved on the next read.
- Macro build: 03h, address 0x000010 with mem[0x10]=0xA5 -> IO1 bits 1,0,1,0,0,1,0,1 at edges 33-40; without the macro -> cmd_err pulse and no drive.
